// File: rtl/barvinn_tb_pkg.sv
// Shared types and default sizing for the BARVINN run supervisor.
package barvinn_tb_pkg;

  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_RST_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    END      = 2'd3
  } run_state_e;

  typedef struct packed {
    logic finished;
    logic timed_out;
    logic stalled;
    logic aborted;
  } run_status_t;

endpackage

// File: rtl/run_ch_capture.sv
// One supervised channel: sticky done bit plus the RUN-cycle stamp of its first done.
module run_ch_capture import barvinn_tb_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_done,
  input  logic [CNT_W-1:0] i_total,
  output logic             o_done,
  output logic             o_new,
  output logic [CNT_W-1:0] o_stamp
);

  logic             r_done;
  logic [CNT_W-1:0] r_stamp;
  logic             w_new;

  assign w_new   = i_en & i_done & ~r_done;
  assign o_new   = w_new;
  assign o_done  = r_done;
  assign o_stamp = r_stamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done  <= 1'b0;
      r_stamp <= '0;
    end else if (i_clr) begin
      r_done  <= 1'b0;
      r_stamp <= '0;
    end else if (w_new) begin
      r_done  <= 1'b1;
      r_stamp <= i_total;
    end
  end

endmodule

// File: rtl/barvinn_run_controller.sv
// Cycle-based run supervisor: sequences DUT reset, stamps per-channel completion,
// and ends the run on abort, all-done, global timeout or stall.
module barvinn_run_controller import barvinn_tb_pkg::*; #(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CNT_W-1:0]        timeout_cycles_i,
  input  logic [CNT_W-1:0]        stall_limit_i,
  input  logic [NUM_CH-1:0]       ch_done_i,
  input  logic [NUM_CH-1:0]       ch_active_i,
  output logic                    dut_rst_n_o,
  output logic                    running_o,
  output logic                    finished_o,
  output logic                    timed_out_o,
  output logic                    stalled_o,
  output logic                    aborted_o,
  output logic [NUM_CH-1:0]       done_mask_o,
  output logic [NUM_CH*CNT_W-1:0] ch_cycles_o,
  output logic [CNT_W-1:0]        total_cycles_o,
  output run_state_e              dbg_state_o
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e       r_state;
  run_status_t      r_status;
  logic             r_dut_rst_n;
  logic             r_running;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_timeout;
  logic [CNT_W-1:0] r_stall_lim;

  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_new;
  logic              w_start;
  logic              w_in_run;
  logic              w_all_done;
  logic              w_activity;
  logic              w_abort_hit;
  logic              w_timeout_hit;
  logic              w_stall_hit;
  logic [CNT_W-1:0]  w_total_inc;
  logic [CNT_W-1:0]  w_stall_inc;

  assign w_start  = start_i & ((r_state == IDLE) | (r_state == END));
  assign w_in_run = (r_state == RUN);

  // Done bits are captured on every RUN cycle, including the one that ends the run.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    run_ch_capture #(.CNT_W(CNT_W)) u_cap (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_start),
      .i_en    (w_in_run),
      .i_done  (ch_done_i[g]),
      .i_total (r_total),
      .o_done  (w_done[g]),
      .o_new   (w_new[g]),
      .o_stamp (ch_cycles_o[g*CNT_W +: CNT_W])
    );
  end

  assign w_all_done    = &(w_done | w_new);
  assign w_activity    = (|ch_active_i) | (|w_new);
  assign w_abort_hit   = abort_i & ((r_state == RST_HOLD) | w_in_run);
  assign w_timeout_hit = (r_timeout != '0) && (r_total == r_timeout - CNT_W'(1)) && !w_all_done;
  assign w_stall_hit   = (r_stall_lim != '0) && !w_activity &&
                         (r_stall_cnt == r_stall_lim - CNT_W'(1));
  assign w_total_inc   = (&r_total) ? r_total : r_total + CNT_W'(1);
  assign w_stall_inc   = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_status    <= '0;
      r_dut_rst_n <= 1'b0;
      r_running   <= 1'b0;
      r_rst_cnt   <= '0;
      r_total     <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= '0;
      r_stall_lim <= '0;
    end else begin
      unique case (r_state)
        IDLE, END: begin
          if (start_i) begin
            r_state     <= RST_HOLD;
            r_status    <= '0;
            r_dut_rst_n <= 1'b0;
            r_rst_cnt   <= '0;
            r_total     <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= timeout_cycles_i;
            r_stall_lim <= stall_limit_i;
          end
        end
        RST_HOLD: begin
          if (w_abort_hit) begin
            r_state          <= END;
            r_status.aborted <= 1'b1;
            r_dut_rst_n      <= 1'b1;
          end else if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            r_state     <= RUN;
            r_dut_rst_n <= 1'b1;
            r_running   <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end
        RUN: begin
          if (w_abort_hit || w_all_done || w_timeout_hit || w_stall_hit) begin
            r_state   <= END;
            r_running <= 1'b0;
            if (w_abort_hit)        r_status.aborted   <= 1'b1;
            else if (w_all_done)    r_status.finished  <= 1'b1;
            else if (w_timeout_hit) r_status.timed_out <= 1'b1;
            else                    r_status.stalled   <= 1'b1;
          end else begin
            r_total     <= w_total_inc;
            r_stall_cnt <= w_activity ? '0 : w_stall_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dut_rst_n_o    = r_dut_rst_n;
  assign running_o      = r_running;
  assign finished_o     = r_status.finished;
  assign timed_out_o    = r_status.timed_out;
  assign stalled_o      = r_status.stalled;
  assign aborted_o      = r_status.aborted;
  assign done_mask_o    = w_done;
  assign total_cycles_o = r_total;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_barvinn_run_controller.sv
// Self-checking bench for barvinn_run_controller (4 channels, 16-bit counters, 4-cycle reset hold).
module tb_barvinn_run_controller;
  import barvinn_tb_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int RC  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic [W-1:0] timeout_cycles_i = '0;
  logic [W-1:0] stall_limit_i = '0;
  logic [NCH-1:0] ch_done_i = '0;
  logic [NCH-1:0] ch_active_i = '0;
  logic dut_rst_n_o, running_o, finished_o, timed_out_o, stalled_o, aborted_o;
  logic [NCH-1:0] done_mask_o;
  logic [NCH*W-1:0] ch_cycles_o;
  logic [W-1:0] total_cycles_o;
  run_state_e dbg_state_o;

  int n_chk = 0;
  int n_fail = 0;
  int run_cyc = 0;
  logic [W-1:0] exp_q[$];
  int exp_ch_q[$];
  logic [NCH-1:0] prev_mask = '0;

  barvinn_run_controller #(.NUM_CH(NCH), .CNT_W(W), .RST_CYCLES(RC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .timeout_cycles_i (timeout_cycles_i),
    .stall_limit_i    (stall_limit_i),
    .ch_done_i        (ch_done_i),
    .ch_active_i      (ch_active_i),
    .dut_rst_n_o      (dut_rst_n_o),
    .running_o        (running_o),
    .finished_o       (finished_o),
    .timed_out_o      (timed_out_o),
    .stalled_o        (stalled_o),
    .aborted_o        (aborted_o),
    .done_mask_o      (done_mask_o),
    .ch_cycles_o      (ch_cycles_o),
    .total_cycles_o   (total_cycles_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a stamp is pushed when a done bit is driven, popped when the mask bit rises
  task automatic expect_done(input int ch);
    exp_q.push_back(W'(run_cyc));
    exp_ch_q.push_back(ch);
  endtask

  task automatic scoreboard();
    logic [NCH-1:0] rose;
    rose = done_mask_o & ~prev_mask;
    for (int i = 0; i < NCH; i++) begin
      if (rose[i]) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 64'(exp_q.size()), 64'd1);
        end else begin
          check("sb_channel", 64'(i), 64'(exp_ch_q.pop_front()));
          check("sb_stamp", 64'(ch_cycles_o[i*W +: W]), 64'(exp_q.pop_front()));
        end
      end
    end
    prev_mask = done_mask_o;
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
    run_cyc++;
    scoreboard();
  endtask

  task automatic start_run(input logic [W-1:0] to, input logic [W-1:0] sl);
    timeout_cycles_i = to;
    stall_limit_i    = sl;
    ch_done_i        = '0;
    ch_active_i      = '0;
    abort_i          = 1'b0;
    start_i          = 1'b1;
    tick();
    start_i          = 1'b0;
    timeout_cycles_i = '0;
    stall_limit_i    = '0;
    check("start_flags_clear", 64'({finished_o, timed_out_o, stalled_o, aborted_o}), 64'd0);
    check("start_mask_clear", 64'(done_mask_o), 64'd0);
    check("start_stamps_clear", 64'(ch_cycles_o), 64'd0);
    for (int i = 0; i < RC; i++) begin
      check("hold_rst_low", 64'(dut_rst_n_o), 64'd0);
      check("hold_not_running", 64'(running_o), 64'd0);
      start_i = (i == 1);
      tick();
    end
    start_i = 1'b0;
    check("run_rst_high", 64'(dut_rst_n_o), 64'd1);
    check("run_running", 64'(running_o), 64'd1);
    check("run_total_zero", 64'(total_cycles_o), 64'd0);
    run_cyc = 0;
  endtask

  task automatic check_end(input logic [3:0] flags, input int total, input logic [NCH-1:0] mask);
    check("end_flags", 64'({finished_o, timed_out_o, stalled_o, aborted_o}), 64'(flags));
    check("end_running", 64'(running_o), 64'd0);
    check("end_dut_rst_n", 64'(dut_rst_n_o), 64'd1);
    check("end_total", 64'(total_cycles_o), 64'(total));
    check("end_mask", 64'(done_mask_o), 64'(mask));
    check("end_state", 64'(dbg_state_o), 64'(END));
  endtask

  task automatic drive_three_done();
    for (int c = 0; c < 3; c++) begin
      if (run_cyc == 10 * (c + 1)) begin
        ch_done_i[c] = 1'b1;
        expect_done(c);
      end
    end
  endtask

  initial begin
    #23;
    check("rst_dut_rst_n", 64'(dut_rst_n_o), 64'd0);
    check("rst_running", 64'(running_o), 64'd0);
    check("rst_flags", 64'({finished_o, timed_out_o, stalled_o, aborted_o}), 64'd0);
    check("rst_mask", 64'(done_mask_o), 64'd0);
    check("rst_stamps", 64'(ch_cycles_o), 64'd0);
    check("rst_total", 64'(total_cycles_o), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Staggered completion, channel 0 done as a one-cycle pulse
    start_run('0, '0);
    while (run_cyc <= 45) begin
      drive_three_done();
      if (run_cyc == 11) ch_done_i[0] = 1'b0;
      if (run_cyc == 40) begin
        ch_done_i[3] = 1'b1;
        expect_done(3);
      end
      tick();
    end
    check_end(4'b1000, 40, 4'hF);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("end_abort_ignored", 64'({finished_o, aborted_o}), 64'b10);

    // Global timeout with channel 3 never done
    start_run(16'd100, '0);
    while (run_cyc <= 105) begin
      drive_three_done();
      tick();
    end
    check_end(4'b0100, 99, 4'b0111);
    check("timeout_ch3_stamp", 64'(ch_cycles_o[3*W +: W]), 64'd0);

    // Stall watchdog, rescued once by activity at idle count 15
    start_run('0, 16'd16);
    while (run_cyc <= 90) begin
      ch_active_i = (run_cyc <= 50 || run_cyc == 66) ? 4'b0101 : 4'b0000;
      if (run_cyc == 70) check("stall_rescued", 64'(running_o), 64'd1);
      tick();
    end
    check_end(4'b0010, 82, 4'h0);

    start_run('0, 16'd16);
    while (run_cyc <= 70) begin
      ch_active_i = (run_cyc <= 50) ? 4'b1000 : 4'b0000;
      tick();
    end
    check_end(4'b0010, 66, 4'h0);

    // Last done on the timeout cycle: finished wins, then abort wins over both
    for (int pass = 0; pass < 2; pass++) begin
      start_run(16'd100, '0);
      while (run_cyc <= 105) begin
        drive_three_done();
        abort_i = (pass == 1) && (run_cyc == 99);
        if (run_cyc == 99) begin
          ch_done_i[3] = 1'b1;
          expect_done(3);
        end
        tick();
      end
      abort_i = 1'b0;
      check_end((pass == 0) ? 4'b1000 : 4'b0001, 99, 4'hF);
    end

    // Asynchronous reset mid-run
    start_run('0, '0);
    while (run_cyc < 25) begin
      if (run_cyc == 5) begin
        ch_done_i[1] = 1'b1;
        expect_done(1);
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dut_rst_n", 64'(dut_rst_n_o), 64'd0);
    check("async_running", 64'(running_o), 64'd0);
    check("async_mask", 64'(done_mask_o), 64'd0);
    check("async_stamps", 64'(ch_cycles_o), 64'd0);
    check("async_total", 64'(total_cycles_o), 64'd0);
    check("async_state", 64'(dbg_state_o), 64'(IDLE));
    ch_done_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(dbg_state_o), 64'(IDLE));

    // Clean restart with all channels finishing together
    start_run('0, '0);
    while (run_cyc <= 8) begin
      if (run_cyc == 3) begin
        ch_done_i = 4'hF;
        for (int c = 0; c < NCH; c++) expect_done(c);
      end
      tick();
    end
    check_end(4'b1000, 3, 4'hF);

    // Restart from END, then abort mid-run
    start_run('0, '0);
    while (run_cyc <= 12) begin
      abort_i = (run_cyc == 7);
      tick();
    end
    abort_i = 1'b0;
    check_end(4'b0001, 7, 4'h0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/barvinn_run_controller.md
Name: barvinn_run_controller

Overview:
- Synthesisable run/supervision controller for multi-channel BARVINN regressions (pito harts / MVU channels).
- Sequences DUT reset, then tracks per-channel completion with cycle-accurate finish stamps.
- Enforces a programmable global timeout and a no-activity stall watchdog, and reports a final status.
- Sits between the testbench clock source and the DUT, replacing the fixed-time `#` watchdog and single done flag with a parametrised, channel-count-generic, cycle-based supervisor.

Parameters:
- NUM_CH, 8, number of supervised channels (harts/MVUs); >=1.
- CNT_W, 32, width of all cycle counters and limit inputs.
- RST_CYCLES, 16, cycles dut_rst_n_o is held low after start; >=1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE or END.
- abort_i  in  1  forces END with aborted_o; ignored in IDLE/END.
- timeout_cycles_i  in  CNT_W  global RUN limit; 0 = disabled; latched on accepted start.
- stall_limit_i  in  CNT_W  max idle cycles; 0 = disabled; latched on accepted start.
- ch_done_i  in  NUM_CH  per-channel done level; the first high cycle in RUN counts.
- ch_active_i  in  NUM_CH  per-channel activity pulses (e.g. instruction retire).
- dut_rst_n_o  out  1  DUT reset, active low.
- running_o  out  1  high in RUN.
- finished_o  out  1  all channels done (sticky until next start).
- timed_out_o  out  1  global timeout hit (sticky).
- stalled_o  out  1  stall watchdog hit (sticky).
- aborted_o  out  1  abort accepted (sticky).
- done_mask_o  out  NUM_CH  channels completed.
- ch_cycles_o  out  NUM_CH*CNT_W  per-channel finish stamp; channel i at [i*CNT_W +: CNT_W].
- total_cycles_o  out  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset values:
  - state = IDLE.
  - dut_rst_n_o = 0.
  - All flags = 0.
  - done_mask_o = 0, ch_cycles_o = 0, total_cycles_o = 0.
  - Latched limits = 0.
  - Reset asserted mid-operation returns everything to these values immediately (async).
- FSM: IDLE -> RST_HOLD -> RUN -> END; END -> RST_HOLD on start_i.
- IDLE / END + start_i:
  - Clear all flags, done_mask, stamps, total, stall counter.
  - Latch both limits.
  - Next state RST_HOLD; dut_rst_n_o = 0 from the next cycle.
- RST_HOLD:
  - dut_rst_n_o low for exactly RST_CYCLES cycles.
  - Then RUN; dut_rst_n_o = 1 on the first RUN cycle.
  - start_i is ignored.
- RUN:
  - total_cycles_o = 0 on the first RUN cycle, then +1 per cycle, saturating at all-ones.
  - Channel i with ch_done_i[i]=1 and done_mask_o[i]=0 sets done_mask_o[i] and stamps ch_cycles_o[i] with the current total.
  - Multiple channels may complete in the same cycle.
  - Later deassertion of ch_done_i does not clear done_mask_o.
- Stall counter (RUN only):
  - Clears on any ch_active_i bit or any new done bit; otherwise increments.
  - stalled_o fires when the counter equals limit-1 with no activity that cycle.
  - Disabled when stall_limit_i was latched as 0.
- Timeout (RUN only): timed_out_o fires on the cycle total == timeout-1 while the mask is incomplete; disabled when latched as 0.
- Termination:
  - On the cycle a terminating condition is detected, next state = END and the matching flag rises in the same next cycle.
  - running_o falls in that same next cycle.
- Same-cycle priority: abort_i > all-done (finished) > timeout > stall. Exactly one flag is set per run.
- END:
  - dut_rst_n_o stays 1 so DUT state remains inspectable.
  - Counters freeze; flags hold.
- NUM_CH=1 must work; the all-done check is a reduction AND over done_mask including the bits set this cycle.

Decomposition:
- Shared package barvinn_tb_pkg:
  - run_state_e enum (IDLE, RST_HOLD, RUN, END).
  - run_status_t packed struct {finished, timed_out, stalled, aborted}.
  - Default localparams for NUM_CH / CNT_W.
- One sub-module: run_ch_capture, one instance per channel via generate. Holds the done bit and stamp register and takes the clear, enable and total inputs.

Test Plan (NUM_CH=4, CNT_W=16, RST_CYCLES=4):
1. Release rst_n, pulse start_i -> dut_rst_n_o low for exactly 4 cycles, then high; running_o=1 and total_cycles_o=0 on the first RUN cycle.
2. ch_done_i bits 0..3 rise at run cycles 10, 20, 30, 40 -> ch_cycles_o = 10/20/30/40, done_mask_o = 4'b1111, finished_o=1, total frozen at 40, other flags 0.
3. timeout=100, channel 3 never done -> timed_out_o=1, done_mask_o=4'b0111, total_cycles_o=99, ch_cycles_o[3]=0.
4. stall_limit=16, activity and done stop after run cycle 50 -> stalled_o=1 after 16 idle cycles; ch_active_i at idle count 15 resets the watchdog.
5. Simultaneous-event priority:
   - Last done on the cycle total=99 with timeout=100 -> finished_o=1, timed_out_o=0.
   - Repeat with abort_i also high -> aborted_o=1 only.
6. Reset and restart:
   - Assert rst_n low at run cycle 25 -> all outputs return to reset values asynchronously.
   - start_i after release -> clean new run.
   - start_i in END -> flags cleared, a new RST_HOLD of 4 cycles.
